// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//
// Target-side model of the CPU data SRAM port. Accepts one request per cycle
// with en=1 (no backpressure) and returns the addressed word on
// data_sram_rdata one cycle later, read-first: a store that also reads
// returns the word as it stood before the store.
//
// Address map:
//   addr[31:16] == MMIO_HI : MMIO window, decoded on addr[15:2]
//     0xF000 LED      rw, only byte lanes 0..1 exist
//     0xF004 SWITCH   ro, 2-flop synchronised board switches
//     0xF008 TIMER    rw, free-running, a write replaces that cycle's increment
//     0xF00C SCRATCH  rw, byte-enabled
//     0xF010 LOAD_CNT  (DATA_SRAM_ACCESS_CNT_EN only) loads seen, write clears
//     0xF014 STORE_CNT (DATA_SRAM_ACCESS_CNT_EN only) stores seen, write clears
//     other offsets read 0, writes are dropped
//   otherwise            : byte-writable RAM of 2**ADDR_WIDTH words, aliased
//
// Optional feature macro: DATA_SRAM_ACCESS_CNT_EN (access counters).
//
// Ports:
//   clk              clock
//   reset            synchronous active-high reset (wins over any request)
//   data_sram_en     access strobe
//   data_sram_wen    byte write enables, 4'h0 = read
//   data_sram_addr   byte address, addr[1:0] ignored
//   data_sram_wdata  store data
//   data_sram_rdata  read data, one cycle after the request
//   led              LED register
//   switch           asynchronous board switches
// ---------------------------------------------------------------------------
module data_sram_responder #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [15:0] MMIO_HI    = 16'hBFAF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   input  logic [7:0]  switch
);

   // Word offsets (byte offset >> 2) inside the MMIO window.
   localparam logic [13:0] OFFW_LED     = 14'h3C00;
   localparam logic [13:0] OFFW_SWITCH  = 14'h3C01;
   localparam logic [13:0] OFFW_TIMER   = 14'h3C02;
   localparam logic [13:0] OFFW_SCRATCH = 14'h3C03;
`ifdef DATA_SRAM_ACCESS_CNT_EN
   localparam logic [13:0] OFFW_LD_CNT  = 14'h3C04;
   localparam logic [13:0] OFFW_ST_CNT  = 14'h3C05;
`endif

   function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
      logic [31:0] r;
      r = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
      end
      return r;
   endfunction

   logic [31:0]           ram [0:(2**ADDR_WIDTH)-1];
   logic [31:0]           timer;
   logic [31:0]           scratch;
   logic [7:0]            sw_meta_p1;
   logic [7:0]            sw_sync_p2;
`ifdef DATA_SRAM_ACCESS_CNT_EN
   logic [31:0]           load_cnt;
   logic [31:0]           store_cnt;
`endif

   // ---- p0: request decode ------------------------------------------------
   logic                  is_mmio_p0;
   logic [13:0]           offw_p0;
   logic [ADDR_WIDTH-1:0] word_idx_p0;
   logic                  load_p0;
   logic                  store_p0;
   logic                  mmio_wr_p0;
   logic                  ram_wr_p0;
   logic [31:0]           mmio_rdata_p0;
   logic                  unused_addr_lsb;

   assign is_mmio_p0      = (data_sram_addr[31:16] == MMIO_HI);
   assign offw_p0         = data_sram_addr[15:2];
   assign word_idx_p0     = data_sram_addr[ADDR_WIDTH+1:2];
   assign load_p0         = data_sram_en && (data_sram_wen == 4'h0);
   assign store_p0        = data_sram_en && (data_sram_wen != 4'h0);
   assign mmio_wr_p0      = store_p0 && is_mmio_p0;
   assign ram_wr_p0       = store_p0 && !is_mmio_p0;
   assign unused_addr_lsb = ^data_sram_addr[1:0];

   always_comb begin
      mmio_rdata_p0 = 32'h0;
      case (offw_p0)
         OFFW_LED:     mmio_rdata_p0 = {16'h0, led};
         OFFW_SWITCH:  mmio_rdata_p0 = {24'h0, sw_sync_p2};
         OFFW_TIMER:   mmio_rdata_p0 = timer;
         OFFW_SCRATCH: mmio_rdata_p0 = scratch;
`ifdef DATA_SRAM_ACCESS_CNT_EN
         OFFW_LD_CNT:  mmio_rdata_p0 = load_cnt;
         OFFW_ST_CNT:  mmio_rdata_p0 = store_cnt;
`endif
         default:      mmio_rdata_p0 = 32'h0;
      endcase
   end

   // ---- p1: state update and registered read data -------------------------
   // RAM is not reset; its write is simply blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && ram_wr_p0) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) ram[word_idx_p0][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_sram_rdata <= 32'h0;
      end else if (data_sram_en) begin
         data_sram_rdata <= is_mmio_p0 ? mmio_rdata_p0 : ram[word_idx_p0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led     <= 16'h0;
         scratch <= 32'h0;
         timer   <= 32'h0;
      end else begin
         if (mmio_wr_p0 && offw_p0 == OFFW_LED) begin
            if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
         end
         if (mmio_wr_p0 && offw_p0 == OFFW_SCRATCH) begin
            scratch <= byte_merge(scratch, data_sram_wdata, data_sram_wen);
         end
         // A store to TIMER takes the place of the increment for that cycle.
         if (mmio_wr_p0 && offw_p0 == OFFW_TIMER) begin
            timer <= byte_merge(timer, data_sram_wdata, data_sram_wen);
         end else begin
            timer <= timer + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta_p1 <= 8'h0;
         sw_sync_p2 <= 8'h0;
      end else begin
         sw_meta_p1 <= switch;
         sw_sync_p2 <= sw_meta_p1;
      end
   end

`ifdef DATA_SRAM_ACCESS_CNT_EN
   // The clearing store is itself counted, but the clear overrides it, so the
   // counter reads 0 afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt  <= 32'h0;
         store_cnt <= 32'h0;
      end else begin
         if (mmio_wr_p0 && offw_p0 == OFFW_LD_CNT) begin
            load_cnt <= 32'h0;
         end else if (load_p0) begin
            load_cnt <= load_cnt + 32'd1;
         end
         if (mmio_wr_p0 && offw_p0 == OFFW_ST_CNT) begin
            store_cnt <= 32'h0;
         end else if (store_p0) begin
            store_cnt <= store_cnt + 32'd1;
         end
      end
   end
`else
   logic unused_load;
   assign unused_load = load_p0;
`endif

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Target-side model of the CPU data SRAM port: services the en/wen/addr/wdata requests the execute stage issues and returns read data one cycle later on data_sram_rdata.
- Holds a byte-writable word RAM plus a small MMIO window (LED, switch, free-running timer, scratch).
- Sits in the SoC top beside the CPU core.

Parameters:
- ADDR_WIDTH, 12, word-address bits of the RAM (4096 words = 16 KB); RAM aliases across the rest of the non-MMIO space.
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window instead of RAM.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- data_sram_en  input  1  access strobe; no access when 0
- data_sram_wen  input  4  byte write enables; wen[i] writes wdata[8i+7:8i]; 4'h0 = read
- data_sram_addr  input  32  byte address; addr[1:0] ignored
- data_sram_wdata  input  32  store data
- data_sram_rdata  output  32  read data, valid the cycle after the request
- led  output  16  LED register value
- switch  input  8  asynchronous board switches

Behaviour:
- Interface: reset, synchronous, active-high; clock clk. All state updates on posedge clk. No backpressure: every cycle with en=1 is accepted.
- Reset values: data_sram_rdata=0, led=0, timer=0, scratch=0, switch synchronisers=0, optional counters=0. RAM contents are not reset.
- Decode: MMIO when addr[31:16]==MMIO_HI, else RAM. RAM word index = addr[ADDR_WIDTH+1:2].
- MMIO offsets (addr[15:0]):
  - 0xF000 LED: rw; wen[1:0] update led bytes; wen[3:2] ignored; reads {16'h0, led}.
  - 0xF004 SWITCH: ro; reads {24'h0, sw_sync}; writes ignored.
  - 0xF008 TIMER: rw, 32-bit.
  - 0xF00C SCRATCH: rw, byte-enabled.
  - Any other offset: reads 0, writes ignored.
- Read latency: exactly 1 cycle. rdata at edge N+1 = selected word as it stood before edge N+1 (read-first).
  - A write plus read of the same word in one request returns the old data.
  - A request in cycle N+1 sees cycle N's write.
- en=0: no write, data_sram_rdata holds its previous value.
- en=1, wen!=0: bytes with wen[i]=1 merge into the target word; rdata also updates with the old word, read-first.
- Timer:
  - Increments by 1 every cycle; 32'hFFFFFFFF wraps to 0.
  - A write to TIMER replaces the increment that cycle: timer <= byte-merge(old, wdata).
  - A read returns the pre-edge value.
- Switch: 2-flop synchroniser; a switch change is visible in a read issued 2 cycles later, with the result on rdata in the 3rd cycle.
- Reset mid-operation: reset has priority over any request that cycle. The write is dropped for MMIO registers; the RAM write is also suppressed while reset=1.

Optional Feature:
- Macro DATA_SRAM_ACCESS_CNT_EN.
- When defined, two 32-bit wrapping counters are added:
  - LOAD_CNT at offset 0xF010: +1 per cycle with en=1 and wen=0.
  - STORE_CNT at offset 0xF014: +1 per cycle with en=1 and wen!=0.
  - Both count RAM and MMIO accesses.
  - Reads return the pre-edge value; writes of any data clear the counter. The clearing write is counted before the clear, so the counter reads 0 afterwards.
- When undefined, 0xF010/0xF014 behave as unmapped (read 0) and the counters are not built.

Test Plan:
- RAM write/read: write wen=4'hF, addr 0x00000100, wdata 0x12345678; next cycle read 0x100 -> rdata=0x12345678 one cycle after the read request.
- Byte merge: over the previous word, write wen=4'b0101 wdata 0xAABBCCDD -> read returns 0x12BB56DD. Same-cycle write+read of a word returns old data, and the new data on the following read.
- en=0 hold: after rdata=0x12BB56DD, hold en=0 for 5 cycles -> rdata stays 0x12BB56DD. Aliasing: read 0x00004100 with ADDR_WIDTH=12 -> 0x12BB56DD.
- Timer: two reads of 0xBFAFF008 issued 10 cycles apart differ by 10. Write 0xFFFFFFFE -> reads 2 and 3 cycles later return 0xFFFFFFFF and 0x00000000 (wrap).
- MMIO: write 0xBFAFF000 wdata 0xFFFF00A5 wen=4'hF -> led=16'h00A5. Set switch=8'h3C -> a read of 0xBFAFF004 issued 2+ cycles later returns 0x0000003C. A read of 0xBFAFF020 returns 0.
- Reset mid-run: assert reset during a store to 0xBFAFF00C -> scratch=0, led=0, rdata=0, timer restarts at 0. With DATA_SRAM_ACCESS_CNT_EN: 3 loads + 2 stores -> 0xF010 reads 3 (counting this read after), 0xF014 reads 2.
